// File: rtl/npu_seq_pkg.sv
// Shared types and sizing helpers for the systolic-array sequencer.
// The optional NPU_SEQ_TIMEOUT_EN build adds a bounded drain with a sticky timeout flag.
package npu_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      CAPTURE,
      DONE
   } seq_state_t;

   // Accumulator width: int8*int8 products plus one growth bit per extra term.
   function automatic int acc_width(input int n);
      return 16 + n - 1;
   endfunction

   // Cycles needed to push the last skewed operand into the far corner PE.
   function automatic int feed_len(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/npu_array_sequencer_if.sv
// Edge bus between the sequencer (master) and the NxN systolic MAC array (slave).
interface npu_array_sequencer_if
   import npu_seq_pkg::*;
#(
   parameter int N = 2
);
   localparam int ACC_W = acc_width(N);

   logic                   arr_clr;
   logic                   arr_en;
   logic [N*8-1:0]         arr_a;
   logic [N*8-1:0]         arr_b;
   logic [N*N-1:0]         arr_pdone;
   logic [N*N*ACC_W-1:0]   arr_out;

   modport master (
      output arr_clr,
      output arr_en,
      output arr_a,
      output arr_b,
      input  arr_pdone,
      input  arr_out
   );

   modport slave (
      input  arr_clr,
      input  arr_en,
      input  arr_a,
      input  arr_b,
      output arr_pdone,
      output arr_out
   );
endinterface

// File: rtl/npu_skew_feeder.sv
// Holds the latched operand matrices and the feed counter, and produces the
// diagonally skewed row (A) and column (B) edge operands as registered outputs.
module npu_skew_feeder
   import npu_seq_pkg::*;
#(
   parameter int N = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [N*N*8-1:0] a_mat,
   input  logic [N*N*8-1:0] b_mat,
   input  logic             feed_now,
   input  logic             feed_next,
   output logic [N*8-1:0]   arr_a,
   output logic [N*8-1:0]   arr_b,
   output logic             feed_last
);
   localparam int FEED_LEN = feed_len(N);
   localparam int T_W      = $clog2(FEED_LEN + 1);

   logic [N*N*8-1:0] a_reg, b_reg;
   logic [T_W-1:0]   t_reg, t_next;
   logic [N*8-1:0]   a_next, b_next;
   logic [N*8-1:0]   arr_a_reg, arr_b_reg;

   // FEED is only entered from CLEAR, so a fresh run always starts at t=0.
   assign t_next    = feed_now ? (t_reg + T_W'(1)) : '0;
   assign feed_last = feed_now && (t_reg == T_W'(FEED_LEN - 1));

   // Lane gi carries A[gi][t-gi] on the row edge and B[t-gi][gi] on the column edge.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [7:0] a_lane, b_lane;

      always_comb begin
         a_lane = '0;
         b_lane = '0;
         for (int k = 0; k < N; k++) begin
            if (t_next == T_W'(gi + k)) begin
               a_lane = a_reg[(gi*N + k)*8 +: 8];
               b_lane = b_reg[(k*N + gi)*8 +: 8];
            end
         end
      end

      assign a_next[gi*8 +: 8] = a_lane;
      assign b_next[gi*8 +: 8] = b_lane;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         t_reg     <= '0;
         arr_a_reg <= '0;
         arr_b_reg <= '0;
      end else begin
         if (load) begin
            a_reg <= a_mat;
            b_reg <= b_mat;
         end
         t_reg     <= feed_next ? t_next : '0;
         arr_a_reg <= feed_next ? a_next : '0;
         arr_b_reg <= feed_next ? b_next : '0;
      end
   end

   assign arr_a = arr_a_reg;
   assign arr_b = arr_b_reg;

endmodule

// File: rtl/npu_array_sequencer.sv
// Sequences one run of the NxN systolic MAC array: latch, clear, skewed feed,
// drain until all PEs report done, capture results. Option: NPU_SEQ_TIMEOUT_EN.
module npu_array_sequencer
   import npu_seq_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [N*N*8-1:0]               a_mat,
   input  logic [N*N*8-1:0]               b_mat,
   output logic                           busy,
   output logic                           done,
   output logic [N*N*acc_width(N)-1:0]    result,
   output logic                           timeout,
   npu_array_sequencer_if.master          arr
);
   localparam int ACC_W = acc_width(N);

   seq_state_t state_reg, state_next;

   logic                 accept;
   logic                 all_done;
   logic                 feed_last;
   logic                 drain_expire;
   logic                 busy_reg, done_reg, clr_reg, en_reg;
   logic [N*N*ACC_W-1:0] result_reg;

   assign accept   = (state_reg == IDLE) && start;
   assign all_done = &arr.arr_pdone;

`ifdef NPU_SEQ_TIMEOUT_EN
   localparam int DRAIN_MAX = 4 * N;
   localparam int D_W       = $clog2(DRAIN_MAX + 1);

   logic [D_W-1:0] drain_cnt_reg;
   logic           timeout_reg;

   assign drain_expire = (state_reg == DRAIN) && !all_done &&
                         (drain_cnt_reg == D_W'(DRAIN_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_cnt_reg <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         drain_cnt_reg <= (state_reg == DRAIN) ? (drain_cnt_reg + D_W'(1)) : '0;
         if (accept) begin
            timeout_reg <= 1'b0;
         end else if (drain_expire) begin
            timeout_reg <= 1'b1;
         end
      end
   end

   assign timeout = timeout_reg;
`else
   assign drain_expire = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = CLEAR;
         CLEAR:   state_next = FEED;
         FEED:    if (feed_last) state_next = DRAIN;
         DRAIN:   if (all_done || drain_expire) state_next = CAPTURE;
         CAPTURE: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they are flop outputs
   // that line up exactly with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         clr_reg    <= 1'b0;
         en_reg     <= 1'b0;
         result_reg <= '0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next != IDLE);
         done_reg  <= (state_next == DONE);
         clr_reg   <= (state_next == CLEAR);
         en_reg    <= (state_next == FEED) || (state_next == DRAIN);
         if (state_reg == CAPTURE) begin
            result_reg <= arr.arr_out;
         end
      end
   end

   npu_skew_feeder #(
      .N (N)
   ) u_feeder (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .a_mat     (a_mat),
      .b_mat     (b_mat),
      .feed_now  (state_reg == FEED),
      .feed_next (state_next == FEED),
      .arr_a     (arr.arr_a),
      .arr_b     (arr.arr_b),
      .feed_last (feed_last)
   );

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign result      = result_reg;
   assign arr.arr_clr = clr_reg;
   assign arr.arr_en  = en_reg;

endmodule

// File: tb/tb_npu_array_sequencer.sv
// Bench for npu_array_sequencer: behavioural systolic array on the edge bus,
// matrix-product reference, randomized operands, one line per transaction.
module tb_npu_array_sequencer;
   localparam int N     = 2;
   localparam int ACC_W = 16 + N - 1;
   localparam int FL    = 3 * N - 2;
   localparam int DMAX  = 4 * N;
   localparam int MW    = N * N * 8;
   localparam int RW    = N * N * ACC_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [MW-1:0] a_mat = '0;
   logic [MW-1:0] b_mat = '0;
   logic          busy, done, timeout;
   logic [RW-1:0] result;

   int errors = 0;
   int checks = 0;

   npu_array_sequencer_if #(.N(N)) arr ();

   npu_array_sequencer #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a_mat   (a_mat),
      .b_mat   (b_mat),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .timeout (timeout),
      .arr     (arr)
   );

   always #5 clk = ~clk;

   // Behavioural array: A moves right, B moves down, each PE accumulates a*b.
   int         acc   [N][N];
   logic [7:0] a_dly [N][N];
   logic [7:0] b_dly [N][N];
   logic       pdone_stuck = 1'b0;
   logic [RW-1:0] arr_out_v;

   always @(posedge clk or posedge rst) begin : array_model
      logic [7:0] av, bv;
      if (rst) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               acc[i][j]   <= 0;
               a_dly[i][j] <= '0;
               b_dly[i][j] <= '0;
            end
      end else if (arr.arr_clr) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) acc[i][j] <= 0;
      end else if (arr.arr_en) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               if (j == 0) av = arr.arr_a[i*8 +: 8];
               else        av = a_dly[i][j-1];
               if (i == 0) bv = arr.arr_b[j*8 +: 8];
               else        bv = b_dly[i-1][j];
               acc[i][j]   <= acc[i][j] + $signed(av) * $signed(bv);
               a_dly[i][j] <= av;
               b_dly[i][j] <= bv;
            end
      end
   end

   always_comb begin
      arr_out_v = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) arr_out_v[(i*N+j)*ACC_W +: ACC_W] = acc[i][j][ACC_W-1:0];
   end

   assign arr.arr_out   = arr_out_v;
   assign arr.arr_pdone = pdone_stuck ? '0 : '1;

   function automatic logic [RW-1:0] matmul(input logic [MW-1:0] am, input logic [MW-1:0] bm);
      logic [RW-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++)
               s += int'($signed(am[(i*N+k)*8 +: 8])) * int'($signed(bm[(k*N+j)*8 +: 8]));
            r[(i*N+j)*ACC_W +: ACC_W] = s[ACC_W-1:0];
         end
      return r;
   endfunction

   function automatic logic [N*8-1:0] edge_a(input logic [MW-1:0] am, input int t);
      logic [N*8-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*8 +: 8] = am[(i*N + (t - i))*8 +: 8];
      return v;
   endfunction

   function automatic logic [N*8-1:0] edge_b(input logic [MW-1:0] bm, input int t);
      logic [N*8-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*8 +: 8] = bm[((t - j)*N + j)*8 +: 8];
      return v;
   endfunction

   function automatic logic [MW-1:0] rand_mat();
      logic [MW-1:0] m;
      for (int k = 0; k < N*N; k++) m[k*8 +: 8] = 8'($urandom());
      return m;
   endfunction

   logic [N*8-1:0] tr_a[$];
   logic [N*8-1:0] tr_b[$];

   // One run: pulse start, scramble inputs after accept, trace until done.
   task automatic do_run(input logic [MW-1:0] am, input logic [MW-1:0] bm,
                         output int busy_cyc, output int clr_cyc, output int en_cyc,
                         output logic clr_first, output logic [RW-1:0] res,
                         output logic got_done, output logic to_flag);
      busy_cyc = 0; clr_cyc = 0; en_cyc = 0; clr_first = 1'b0;
      res = '0; got_done = 1'b0; to_flag = 1'b0;
      tr_a.delete(); tr_b.delete();
      @(negedge clk);
      a_mat = am; b_mat = bm; start = 1'b1;
      for (int c = 0; c < 200 && !got_done; c++) begin
         @(negedge clk);
         if (busy) busy_cyc++;
         if (arr.arr_clr) begin
            clr_cyc++;
            if (en_cyc == 0) clr_first = 1'b1;
         end
         if (arr.arr_en) begin
            en_cyc++;
            if (tr_a.size() < FL) begin
               tr_a.push_back(arr.arr_a);
               tr_b.push_back(arr.arr_b);
            end
         end
         if (done) begin
            got_done = 1'b1; res = result; to_flag = timeout;
         end
         if (c == 0) begin
            start = 1'b0; a_mat = rand_mat(); b_mat = rand_mat();
         end
      end
      $display("run A=%h B=%h -> result=%h busy=%0d en=%0d done=%0d timeout=%0d",
               am, bm, res, busy_cyc, en_cyc, got_done, to_flag);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if ({busy, done, timeout, arr.arr_en, arr.arr_clr} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, timeout, arr.arr_en, arr.arr_clr});
      end
      checks++;
      if ({arr.arr_a, arr.arr_b, result} !== '0) begin
         errors++;
         $display("FAIL reset_data: got a=%h b=%h result=%h expected 0", arr.arr_a, arr.arr_b, result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
      $display("reset applied and released");
   endtask

   task automatic test_basic();
      logic [MW-1:0] am, bm;
      logic [RW-1:0] res, exp_res;
      int bc, cc, ec;
      logic cf, gd, tf;
      am = {8'd4, 8'd3, 8'd2, 8'd1};
      bm = {8'd8, 8'd7, 8'd6, 8'd5};
      exp_res = {17'd50, 17'd43, 17'd22, 17'd19};
      do_run(am, bm, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (gd !== 1'b1 || res !== exp_res) begin
         errors++;
         $display("FAIL basic_result: got done=%b result=%h expected done=1 result=%h", gd, res, exp_res);
      end
      checks++;
      if (bc != 3*N + 2) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, 3*N + 2);
      end
      checks++;
      if (cc != 1 || cf !== 1'b1) begin
         errors++;
         $display("FAIL basic_clear: got count=%0d before_feed=%b expected 1 1", cc, cf);
      end
      checks++;
      if (ec != FL + 1) begin
         errors++;
         $display("FAIL basic_enable_cycles: got %0d expected %0d", ec, FL + 1);
      end
      for (int t = 0; t < FL && t < tr_a.size(); t++) begin
         checks++;
         if (tr_a[t] !== edge_a(am, t) || tr_b[t] !== edge_b(bm, t)) begin
            errors++;
            $display("FAIL basic_skew_t%0d: got a=%h b=%h expected a=%h b=%h",
                     t, tr_a[t], tr_b[t], edge_a(am, t), edge_b(bm, t));
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
         errors++;
         $display("FAIL basic_after_done: got done=%b busy=%b result=%h expected 0 0 %h",
                  done, busy, result, exp_res);
      end
   endtask

   task automatic test_skew();
      logic [N*8-1:0] exp_a [3];
      logic [N*8-1:0] exp_b [3];
      logic [RW-1:0] res;
      int bc, cc, ec;
      logic cf, gd, tf;
      exp_a[0] = 16'h0001; exp_b[0] = 16'h0005;
      exp_a[1] = 16'h0302; exp_b[1] = 16'h0607;
      exp_a[2] = 16'h0400; exp_b[2] = 16'h0800;
      do_run({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (tr_a.size() != FL) begin
         errors++;
         $display("FAIL skew_trace_len: got %0d expected %0d", tr_a.size(), FL);
      end else begin
         for (int t = 0; t < 3; t++) begin
            checks++;
            if (tr_a[t] !== exp_a[t] || tr_b[t] !== exp_b[t]) begin
               errors++;
               $display("FAIL skew_t%0d: got a=%h b=%h expected a=%h b=%h",
                        t, tr_a[t], tr_b[t], exp_a[t], exp_b[t]);
            end
         end
         checks++;
         if (tr_a[FL-1] !== '0 || tr_b[FL-1] !== '0) begin
            errors++;
            $display("FAIL skew_last: got a=%h b=%h expected 0 0", tr_a[FL-1], tr_b[FL-1]);
         end
      end
   endtask

   task automatic test_random();
      logic [MW-1:0] am, bm;
      logic [RW-1:0] res;
      int bc, cc, ec;
      logic cf, gd, tf;
      for (int n = 0; n < 6; n++) begin
         am = rand_mat(); bm = rand_mat();
         do_run(am, bm, bc, cc, ec, cf, res, gd, tf);
         checks++;
         if (gd !== 1'b1 || res !== matmul(am, bm) || tf !== 1'b0) begin
            errors++;
            $display("FAIL random_result_%0d: got done=%b timeout=%b result=%h expected 1 0 %h",
                     n, gd, tf, res, matmul(am, bm));
         end
         for (int t = 0; t < tr_a.size(); t++) begin
            checks++;
            if (tr_a[t] !== edge_a(am, t) || tr_b[t] !== edge_b(bm, t)) begin
               errors++;
               $display("FAIL random_skew_%0d_t%0d: got a=%h b=%h expected a=%h b=%h",
                        n, t, tr_a[t], tr_b[t], edge_a(am, t), edge_b(bm, t));
            end
         end
      end
   endtask

   task automatic test_extremes();
      logic [MW-1:0] m;
      logic [RW-1:0] res, exp_res;
      int bc, cc, ec;
      logic cf, gd, tf;
      m = {N*N{8'h80}};
      exp_res = {N*N{17'h08000}};
      do_run(m, m, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (res !== exp_res || res !== arr.arr_out) begin
         errors++;
         $display("FAIL extremes_result: got %h expected %h (array %h)", res, exp_res, arr.arr_out);
      end
      for (int t = 0; t < tr_a.size(); t++) begin
         checks++;
         if (tr_a[t] !== edge_a(m, t) || tr_b[t] !== edge_b(m, t)) begin
            errors++;
            $display("FAIL extremes_skew_t%0d: got a=%h b=%h expected a=%h b=%h",
                     t, tr_a[t], tr_b[t], edge_a(m, t), edge_b(m, t));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [MW-1:0] am, bm;
      int done_at[$];
      int idle_cnt, waited;
      am = rand_mat(); bm = rand_mat();
      @(negedge clk);
      a_mat = am; b_mat = bm; start = 1'b1;
      idle_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!busy) idle_cnt++;
         if (done) begin
            done_at.push_back(c);
            checks++;
            if (result !== matmul(am, bm)) begin
               errors++;
               $display("FAIL b2b_result_c%0d: got %h expected %h", c, result, matmul(am, bm));
            end
         end
      end
      start = 1'b0;
      $display("back-to-back: %0d done pulses, %0d idle cycles", done_at.size(), idle_cnt);
      checks++;
      if (done_at.size() != 4 || idle_cnt != 4) begin
         errors++;
         $display("FAIL b2b_count: got done=%0d idle=%0d expected 4 4", done_at.size(), idle_cnt);
      end
      for (int k = 0; k < done_at.size(); k++) begin
         checks++;
         if (done_at[k] != 8 + 9*k) begin
            errors++;
            $display("FAIL b2b_done_cycle_%0d: got %0d expected %0d", k, done_at[k], 8 + 9*k);
         end
      end
      waited = 0;
      while (busy && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_settle: got busy=%b expected 0 within 50 cycles", busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [MW-1:0] am, bm;
      logic [RW-1:0] res;
      int bc, cc, ec, en_seen, waited;
      logic cf, gd, tf, saw_done;
      @(negedge clk);
      a_mat = rand_mat(); b_mat = rand_mat(); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      en_seen = 0; waited = 0;
      while (en_seen < 2 && waited < 20) begin
         @(negedge clk);
         waited++;
         if (arr.arr_en) en_seen++;
      end
      checks++;
      if (en_seen < 2) begin
         errors++;
         $display("FAIL midrst_reach_feed: got %0d enable cycles expected 2", en_seen);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, timeout, arr.arr_en, arr.arr_clr} !== 5'b0 ||
          {arr.arr_a, arr.arr_b, result} !== '0) begin
         errors++;
         $display("FAIL midrst_async: got ctrl=%b a=%h b=%h result=%h expected all 0",
                  {busy, done, timeout, arr.arr_en, arr.arr_clr}, arr.arr_a, arr.arr_b, result);
      end
      saw_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      rst = 1'b0;
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL midrst_quiet: got activity=%b expected 0", saw_done);
      end
      $display("reset asserted during FEED and released");
      am = rand_mat(); bm = rand_mat();
      do_run(am, bm, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (gd !== 1'b1 || res !== matmul(am, bm)) begin
         errors++;
         $display("FAIL midrst_rerun: got done=%b result=%h expected 1 %h", gd, res, matmul(am, bm));
      end
   endtask

`ifdef NPU_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      logic [MW-1:0] am, bm;
      logic [RW-1:0] res;
      int bc, cc, ec;
      logic cf, gd, tf;
      pdone_stuck = 1'b1;
      am = rand_mat(); bm = rand_mat();
      do_run(am, bm, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (gd !== 1'b1 || tf !== 1'b1 || res !== matmul(am, bm)) begin
         errors++;
         $display("FAIL timeout_run: got done=%b timeout=%b result=%h expected 1 1 %h",
                  gd, tf, res, matmul(am, bm));
      end
      checks++;
      if (ec != FL + DMAX) begin
         errors++;
         $display("FAIL timeout_drain_len: got %0d enable cycles expected %0d", ec, FL + DMAX);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: got %b expected 1", timeout);
      end
      pdone_stuck = 1'b0;
      am = rand_mat(); bm = rand_mat();
      do_run(am, bm, bc, cc, ec, cf, res, gd, tf);
      checks++;
      if (gd !== 1'b1 || tf !== 1'b0 || ec != FL + 1) begin
         errors++;
         $display("FAIL timeout_clear: got done=%b timeout=%b en=%0d expected 1 0 %0d", gd, tf, ec, FL + 1);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_skew();
      test_random();
      test_extremes();
      test_back_to_back();
      test_reset_mid_run();
`ifdef NPU_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
